instr_encode_loader: RTL and testbench

Inverse of the datapath's immediate extend logic: accepts decoded instruction fields plus a sign-extended 32-bit immediate and packs them back into a 32-bit RV32I instruction word in I, S, B or R format. It writes each packed word into instruction memory at an auto-incrementing word address through a request/acknowledge write port. It sits between the self-test/program-load sequencer and the instruction memory of the single-cycle processor, and loads programs before the core is released from reset.

---
 rtl/instr_encode_loader.sv | 145 ++++++++++++++
 tb/tb_instr_encode_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs decoded RV32I fields (I/S/B/R) back into an
// instruction word and writes it to instruction memory at an
// auto-incrementing word address over a request/acknowledge port.
// Optional build macro: IMM_CHECK_EN enables immediate range checking and a
// sticky err flag; without it out-of-range immediate bits are truncated and
// err is tied low.
//
// state | meaning
// IDLE  | waiting for a field bundle; in_ready high unless flush
// WRITE | mem_we held with stable addr/data until mem_ack
// FULL  | MAX_WORDS words written; only flush or rst leaves
module instr_encode_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_imm_src,
  input  logic [31:0]                  in_imm,
  input  logic [6:0]                   in_opcode,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [2:0]                   in_funct3,
  input  logic [6:0]                   in_funct7,
  input  logic                         flush,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic                         mem_ack,
  output logic [$clog2(MAX_WORDS):0]   word_count,
  output logic                         full,
  output logic                         err
);

  localparam int CW = $clog2(MAX_WORDS) + 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   packed_word;
  logic          imm_ok;
  logic [CW-1:0] count_next;

  assign in_ready   = (state == IDLE) && !flush;
  assign count_next = word_count + 1'b1;

  // Reassemble the instruction word from fields according to format
  always_comb begin
    packed_word = 32'h0;
    case (in_imm_src)
      2'b00: packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      2'b01: packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], in_opcode};
      2'b10: packed_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
      default: packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    endcase
  end

`ifdef IMM_CHECK_EN
  // Immediate must be representable in the target format's field
  always_comb begin
    imm_ok = 1'b1;
    case (in_imm_src)
      2'b00, 2'b01: imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
      2'b10:        imm_ok = !in_imm[0] && ((&in_imm[31:12]) || !(|in_imm[31:12]));
      default:      imm_ok = 1'b1;
    endcase
  end

  // Sticky error: only rst clears it, flush deliberately leaves it set
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (in_valid && in_ready && !imm_ok)
      err <= 1'b1;
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:13];
  assign imm_ok        = 1'b1;
  assign err           = 1'b0;
`endif

  // Sequencing FSM with registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'h0;
      word_count <= '0;
      full       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
          end else if (in_valid && imm_ok) begin
            mem_wdata <= packed_word;
            mem_we    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          // flush is not honoured here; the pending word must complete
          if (mem_ack) begin
            mem_we     <= 1'b0;
            mem_addr   <= mem_addr + 32'd4;
            word_count <= count_next;
            if (count_next == COUNT_MAX) begin
              state <= FULL;
              full  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        FULL: begin
          if (flush) begin
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
            full       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          full   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader (BASE_ADDR=0x100, MAX_WORDS=4).
// Stimulus pushes expected {addr,data} pairs; a memory responder/monitor
// pops and compares whenever it acknowledges a write.
module tb_instr_encode_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_imm_src;
  logic [31:0] in_imm;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        flush;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  word_count;
  logic        full;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb[$];
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  int          wait_cnt = 0;
  bit          after_ack = 1'b0;
  logic [31:0] hold_addr, hold_data;

  instr_encode_loader #(.BASE_ADDR(BASE), .MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm_src(in_imm_src), .in_imm(in_imm), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .flush(flush), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .word_count(word_count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder and scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (after_ack) begin
      checks++;
      if (mem_we !== 1'b0 || in_ready !== !full) begin
        errors++;
        $display("FAIL ack_release: mem_we=%0b in_ready=%0b full=%0b", mem_we, in_ready, full);
      end
      after_ack = 1'b0;
    end
    if (rst) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_we) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write: got %0b expected 0", in_ready);
      end
      if (wait_cnt == 0) begin
        hold_addr = mem_addr;
        hold_data = mem_wdata;
      end else begin
        checks++;
        if (mem_addr !== hold_addr || mem_wdata !== hold_data) begin
          errors++;
          $display("FAIL hold: got %08h/%08h expected %08h/%08h",
                   mem_addr, mem_wdata, hold_addr, hold_data);
        end
      end
      if (ack_en && wait_cnt >= ack_delay) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got %08h@%08h expected none", mem_wdata, mem_addr);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          if (mem_addr !== e[63:32] || mem_wdata !== e[31:0]) begin
            errors++;
            $display("FAIL write: got %08h@%08h expected %08h@%08h",
                     mem_wdata, mem_addr, e[31:0], e[63:32]);
          end
        end
        mem_ack   = 1'b1;
        wait_cnt  = 0;
        after_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Present one bundle; expect_write selects whether a write request follows
  task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input bit expect_write,
                      input logic [31:0] exp_addr, input logic [31:0] exp_data);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
      return;
    end
    in_imm_src = src; in_imm = imm; in_opcode = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7;
    in_valid = 1'b1;
    if (expect_write) sb.push_back({exp_addr, exp_data});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("we_after_handshake", {31'd0, mem_we}, {31'd0, expect_write});
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (mem_we === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: mem_we=%0b expected 0", mem_we);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    in_imm_src = 2'b00; in_imm = 32'h0; in_opcode = 7'h0; in_rd = 5'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_count", {29'd0, word_count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // I-type, ack in first WRITE cycle
    ack_delay = 0;
    send(2'b00, 32'd5, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 1'b1, BASE, 32'h0050_0093);
    wait_idle();
    chk("i_count", {29'd0, word_count}, 32'd1);
    chk("i_addr_next", mem_addr, BASE + 32'd4);

    // S then B, ack delayed 3 cycles
    ack_delay = 3;
    send(2'b01, 32'd8, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 1'b1, BASE + 32'd4, 32'h0020_A423);
    send(2'b10, 32'hFFFF_FFFC, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 1'b1,
         BASE + 32'd8, 32'hFE20_8EE3);
    wait_idle();
    chk("sb_count", {29'd0, word_count}, 32'd3);

    // R-type fills the 4-word memory
    ack_delay = 0;
    send(2'b11, 32'h0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 1'b1, BASE + 32'd12, 32'h0020_81B3);
    wait_idle();
    chk("full_count", {29'd0, word_count}, 32'd4);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_ready", {31'd0, in_ready}, 32'd0);

    // in_valid ignored in FULL
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_no_write", {31'd0, mem_we}, 32'd0);
    end
    in_valid = 1'b0;
    chk("full_count_hold", {29'd0, word_count}, 32'd4);

    // flush out of FULL
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_addr", mem_addr, BASE);
    chk("flush_count", {29'd0, word_count}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_full", {31'd0, full}, 32'd0);

    // flush beats a simultaneous in_valid in IDLE
    flush = 1'b1; in_valid = 1'b1; in_imm_src = 2'b11;
    #1 chk("flush_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("flush_wins", {31'd0, mem_we}, 32'd0);

    // one write, then a write left unacknowledged
    send(2'b11, 32'h0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 1'b1, BASE, 32'h0020_81B3);
    wait_idle();
    ack_en = 1'b0;
    send(2'b00, 32'd5, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 1'b1, 32'h0, 32'h0);
    void'(sb.pop_back());
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_in_write_we", {31'd0, mem_we}, 32'd1);
    chk("flush_in_write_addr", mem_addr, BASE + 32'd4);
    chk("flush_in_write_count", {29'd0, word_count}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_write_we", {31'd0, mem_we}, 32'd0);
    chk("rst_write_addr", mem_addr, BASE);
    chk("rst_write_count", {29'd0, word_count}, 32'd0);
    ack_en = 1'b1;

    // immediate range handling
`ifdef IMM_CHECK_EN
    send(2'b00, 32'd2048, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 1'b0, 32'h0, 32'h0);
    chk("imm_i_err", {31'd0, err}, 32'd1);
    chk("imm_i_count", {29'd0, word_count}, 32'd0);
    send(2'b10, 32'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 1'b0, 32'h0, 32'h0);
    chk("imm_b_err", {31'd0, err}, 32'd1);
    chk("imm_b_addr", mem_addr, BASE);
    send(2'b00, 32'd5, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 1'b1, BASE, 32'h0050_0093);
    wait_idle();
    chk("imm_ok_count", {29'd0, word_count}, 32'd1);
    chk("imm_err_sticky", {31'd0, err}, 32'd1);
`else
    send(2'b00, 32'd2048, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 1'b1, BASE, 32'h8000_0093);
    send(2'b10, 32'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 1'b1, BASE + 32'd4, 32'h0020_8163);
    send(2'b00, 32'd5, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 1'b1, BASE + 32'd8, 32'h0050_0093);
    wait_idle();
    chk("trunc_count", {29'd0, word_count}, 32'd3);
    chk("trunc_err", {31'd0, err}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
